nes_controller_reader: RTL and testbench

NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

---
 rtl/nes_controller_reader.sv | 135 +++++++++++++
 tb/tb_nes_controller_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//   Polls a standard NES pad once every POLL_CYCLES clocks: pulses the latch,
//   clocks out eight serial bits and publishes them as an active-high button
//   vector. A reset asserted mid-poll aborts the poll, so no partial result
//   can reach the outputs.
//
// Ports
//   clk           system clock
//   hard_reset    synchronous, active-high reset
//   nes_data      pad serial data, active-low, asynchronous to clk
//   nes_latch     pad latch strobe (registered)
//   nes_clk       pad shift clock, idles low (registered)
//   buttons       [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   start         buttons[3]
//   buttons_valid one-cycle pulse when buttons is updated
//   ready         set after the first completed poll, cleared by reset
module nes_controller_reader #(
    parameter int POLL_CYCLES = 1666666,
    parameter int HALF_CYCLES = 600
) (
    input  logic       clk,
    input  logic       hard_reset,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       start,
    output logic       buttons_valid,
    output logic       ready
);

    localparam int CW = $clog2(POLL_CYCLES);
    localparam int PW = $clog2(2 * HALF_CYCLES);

    localparam logic [CW-1:0] PERIOD_LAST = CW'(POLL_CYCLES - 1);
    localparam logic [PW-1:0] LATCH_LAST  = PW'(2 * HALF_CYCLES - 1);
    localparam logic [PW-1:0] HALF_LAST   = PW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [2:0]    idx, idx_n;
    logic          sample;
    logic [CW-1:0] period_cnt;
    logic          data_s1, data_s2;
    logic [7:0]    shift;

    assign start = buttons[3];

    always_comb begin
        state_n = state;
        phase_n = phase + 1'b1;
        idx_n   = idx;
        sample  = 1'b0;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (period_cnt == PERIOD_LAST) state_n = LATCH;
            end
            LATCH: begin
                if (phase == LATCH_LAST) begin
                    state_n = LOW;
                    phase_n = '0;
                    idx_n   = 3'd0;
                end
            end
            LOW: begin
                // Last LOW cycle: the pad has had a full half-period (plus the
                // synchronizer delay) to settle the bit for this index.
                if (phase == HALF_LAST) begin
                    sample  = 1'b1;
                    state_n = HIGH;
                    phase_n = '0;
                end
            end
            HIGH: begin
                if (phase == HALF_LAST) begin
                    phase_n = '0;
                    if (idx == 3'd7) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 3'd1;
                        state_n = LOW;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                phase_n = '0;
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state         <= IDLE;
            phase         <= '0;
            idx           <= 3'd0;
            period_cnt    <= '0;
            data_s1       <= 1'b1;
            data_s2       <= 1'b1;
            shift         <= 8'h00;
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
            ready         <= 1'b0;
            nes_latch     <= 1'b0;
            nes_clk       <= 1'b0;
        end else begin
            data_s1    <= nes_data;
            data_s2    <= data_s1;
            period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
            state      <= state_n;
            phase      <= phase_n;
            idx        <= idx_n;
            // Pad outputs are decoded from the next state so they are
            // registered yet aligned with the state they belong to.
            nes_latch  <= (state_n == LATCH);
            nes_clk    <= (state_n == HIGH);
            if (sample) shift[idx] <= ~data_s2;
            // Only DONE copies the shift register, so a mid-poll value never
            // appears on buttons.
            buttons_valid <= (state == DONE);
            if (state == DONE) begin
                buttons <= shift;
                ready   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

    localparam int POLL = 64;
    localparam int HALF = 2;

    logic       clk = 1'b0;
    logic       hard_reset;
    logic       nes_data;
    logic       nes_latch, nes_clk, start, buttons_valid, ready;
    logic [7:0] buttons;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pressed = 8'h00;
    logic [7:0] pad_reg = 8'hFF;
    logic       noise = 1'b0;
    logic       noise_en = 1'b0;

    always #5 clk = ~clk;

    // Noise toggles only while both pad lines are low, i.e. away from the
    // cycle whose value the synchronizer delivers at the sample edge.
    assign nes_data = pad_reg[0] ^ (noise_en & noise & ~nes_clk & ~nes_latch);

    nes_controller_reader #(.POLL_CYCLES(POLL), .HALF_CYCLES(HALF)) dut (
        .clk(clk), .hard_reset(hard_reset), .nes_data(nes_data),
        .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
        .start(start), .buttons_valid(buttons_valid), .ready(ready)
    );

    // Pad model: 4021-style, loads on latch, shifts on nes_clk rising edge.
    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) pad_reg = ~pressed;
        else           pad_reg = {1'b1, pad_reg[7:1]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    int cyc = 0;
    int ref_cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (hard_reset) ref_cyc = cyc;
    end

    logic       prev_latch = 1'b0, prev_clk = 1'b0, prev_valid = 1'b0;
    int         lat_run = 0, hi_run = 0, lo_run = 0, pulses = 0, nvalid = 0;
    logic [7:0] last_buttons = 8'h00;
    logic [7:0] mon_exp;

    // Monitor: waveform timing plus scoreboard pop on every buttons_valid.
    always @(negedge clk) begin
        if (hard_reset) begin
            lat_run = 0; hi_run = 0; lo_run = 0; pulses = 0;
            last_buttons = 8'h00;
        end else begin
            chk("no_overlap", {31'd0, nes_latch & nes_clk}, 0);
            if (nes_latch && !prev_latch) begin
                chk("latch_period", cyc - ref_cyc, POLL);
                ref_cyc = cyc;
                pulses = 0;
            end
            if (nes_latch) begin
                lat_run++;
                lo_run = 0;
            end else if (prev_latch) begin
                chk("latch_width", lat_run, 2 * HALF);
                lat_run = 0;
            end
            if (nes_clk && !prev_clk) begin
                chk("clk_low", lo_run, HALF);
                pulses++;
            end
            if (nes_clk) begin
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_clk) begin
                    chk("clk_high", hi_run, HALF);
                    hi_run = 0;
                end
                if (!nes_latch) lo_run++;
            end
            if (prev_valid) chk("valid_pulse", {31'd0, buttons_valid}, 0);
            if (buttons_valid) begin
                nvalid++;
                chk("pulses_per_poll", pulses, 8);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid buttons=%h required=none", buttons);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("buttons", {24'd0, buttons}, {24'd0, mon_exp});
                    chk("start", {31'd0, start}, {31'd0, mon_exp[3]});
                    chk("ready", {31'd0, ready}, 1);
                end
                last_buttons = buttons;
            end else begin
                chk("hold", {24'd0, buttons}, {24'd0, last_buttons});
            end
        end
        prev_latch = nes_latch;
        prev_clk   = nes_clk;
        prev_valid = buttons_valid;
    end

    task automatic wait_poll(input string name);
        int n0 = nvalid;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (nvalid > n0) break;
        end
        if (nvalid == n0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_valid required=valid", name);
        end
    endtask

    task automatic next_poll(input logic [7:0] p);
        pressed = p;
        exp_q.push_back(p);
    endtask

    initial begin
        int nrise;
        logic pc;
        hard_reset = 1'b1;
        fork
            forever begin
                @(posedge clk);
                #1;
                noise = ~noise;
            end
        join_none

        // Reset held for 3 edges, outputs checked while held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_buttons", {24'd0, buttons}, 0);
        chk("rst_ctl", {27'd0, nes_latch, nes_clk, buttons_valid, ready, start}, 0);
        next_poll(8'h08);
        @(posedge clk);
        #1 hard_reset = 1'b0;

        wait_poll("start_only");
        next_poll(8'h00); wait_poll("all_released");
        next_poll(8'hFF); wait_poll("all_pressed");
        next_poll(8'h81); wait_poll("right_a");

        noise_en = 1'b1;
        next_poll(8'h5A); wait_poll("noise");

        // Abort a poll during HIGH of bit 3 (fourth nes_clk pulse).
        pressed = 8'h08;
        nrise = 0;
        pc = 1'b0;
        for (int i = 0; i < 200 && nrise < 4; i++) begin
            @(negedge clk);
            if (nes_clk && !pc) nrise++;
            pc = nes_clk;
        end
        chk("abort_reach_bit3", nrise, 4);
        @(posedge clk);
        #1 hard_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_buttons", {24'd0, buttons}, 0);
        chk("abort_ready", {31'd0, ready}, 0);
        chk("abort_nes_clk", {31'd0, nes_clk}, 0);
        chk("abort_start", {31'd0, start}, 0);
        @(posedge clk);
        #1 hard_reset = 1'b0;
        next_poll(8'h08); wait_poll("after_abort");

        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
